// File: rtl/rf_wb_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
package rf_wb_pkg;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 2 ** AW;
    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_MEM = 1'b1
    } grant_t;
endpackage

// File: rtl/rf_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester favoured on
// the next contended cycle and only moves when both requesters collide.
module rf_rr_arb2
    import rf_wb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output grant_t     rr_ptr
);
    grant_t rr_q, rr_d;

    always_comb begin
        gnt  = 2'b00;
        rr_d = rr_q;
        if (!reset) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11: begin
                    gnt  = (rr_q == GNT_ALU) ? 2'b01 : 2'b10;
                    rr_d = (rr_q == GNT_ALU) ? GNT_MEM : GNT_ALU;
                end
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_q <= GNT_ALU;
        else       rr_q <= rr_d;
    end

    assign rr_ptr = rr_q;
endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler with busy-bit scoreboard.
// Optional RF_WB_BYPASS_EN: exposes the retiring write as a bypass and stops stalling on it.
module rf_wb_scheduler
    import rf_wb_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   q_rs1,
    input  logic [AW-1:0]   q_rs2,
    output logic            stall,
    input  logic            a_valid,
    input  logic [AW-1:0]   a_rd,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            m_valid,
    input  logic [AW-1:0]   m_rd,
    input  logic [XLEN-1:0] m_data,
    output logic            m_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_wd,
    output logic [AW:0]     pend_cnt
`ifdef RF_WB_BYPASS_EN
    ,
    output logic            byp1_hit,
    output logic            byp2_hit,
    output logic [XLEN-1:0] byp_data
`endif
);
    logic [1:0]      gnt;
    grant_t          rr_ptr, win;
    logic            granted;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;

    logic            we_q;
    logic [AW-1:0]   rd_q;
    logic [XLEN-1:0] wd_q;
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     pend_q, pend_d;
    logic            ret1, ret2, retd, set_en, inc, dec;

    rf_rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({m_valid, a_valid}),
        .gnt    (gnt),
        .rr_ptr (rr_ptr)
    );

    assign a_ready = gnt[0];
    assign m_ready = gnt[1];
    assign granted = |gnt;

    // Under contention the pointer picks the winner; otherwise the lone requester.
    always_comb begin
        if (a_valid && m_valid) win = rr_ptr;
        else                    win = m_valid ? GNT_MEM : GNT_ALU;
        sel_rd   = (win == GNT_MEM) ? m_rd   : a_rd;
        sel_data = (win == GNT_MEM) ? m_data : a_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q <= 1'b0;
            rd_q <= '0;
            wd_q <= '0;
        end else begin
            we_q <= granted && (sel_rd != REG_ZERO);
            if (granted) begin
                rd_q <= sel_rd;
                wd_q <= sel_data;
            end
        end
    end

    assign rf_we = we_q;
    assign rf_rd = rd_q;
    assign rf_wd = wd_q;

`ifdef RF_WB_BYPASS_EN
    assign ret1     = we_q && (rd_q == q_rs1);
    assign ret2     = we_q && (rd_q == q_rs2);
    assign retd     = we_q && (rd_q == issue_rd);
    assign byp1_hit = ret1 && (q_rs1 != REG_ZERO);
    assign byp2_hit = ret2 && (q_rs2 != REG_ZERO);
    assign byp_data = wd_q;
`else
    assign ret1 = 1'b0;
    assign ret2 = 1'b0;
    assign retd = 1'b0;
`endif

    assign stall = issue_valid &&
                   ((q_rs1    != REG_ZERO && busy_q[q_rs1]    && !ret1) ||
                    (q_rs2    != REG_ZERO && busy_q[q_rs2]    && !ret2) ||
                    (issue_rd != REG_ZERO && busy_q[issue_rd] && !retd));

    assign set_en = issue_valid && !stall && (issue_rd != REG_ZERO);
    // A set on an already-busy register (retiring same cycle) keeps the count; set wins.
    assign inc = set_en && !busy_q[issue_rd];
    assign dec = we_q && busy_q[rd_q] && !(set_en && issue_rd == rd_q);

    always_comb begin
        busy_d = busy_q;
        if (we_q)   busy_d[rd_q]     = 1'b0;
        if (set_en) busy_d[issue_rd] = 1'b1;
        pend_d = pend_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end

    assign pend_cnt = pend_q;
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Randomized self-checking bench for rf_wb_scheduler with an abstract scoreboard model.
module tb_rf_wb_scheduler;
    import rf_wb_pkg::*;

`ifdef RF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0, reset = 1'b1;
    logic            issue_valid = 1'b0;
    logic [AW-1:0]   issue_rd = '0, q_rs1 = '0, q_rs2 = '0;
    logic            stall;
    logic            a_valid = 1'b0, m_valid = 1'b0;
    logic [AW-1:0]   a_rd = '0, m_rd = '0;
    logic [XLEN-1:0] a_data = '0, m_data = '0;
    logic            a_ready, m_ready, rf_we;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_wd;
    logic [AW:0]     pend_cnt;
`ifdef RF_WB_BYPASS_EN
    logic            byp1_hit, byp2_hit;
    logic [XLEN-1:0] byp_data;
`endif

    rf_wb_scheduler dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .stall(stall),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .m_valid(m_valid), .m_rd(m_rd), .m_data(m_data), .m_ready(m_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd), .pend_cnt(pend_cnt)
`ifdef RF_WB_BYPASS_EN
        , .byp1_hit(byp1_hit), .byp2_hit(byp2_hit), .byp_data(byp_data)
`endif
    );

    always #5 clk = ~clk;

    // Model state: set of busy registers, the write in flight, and who is favoured.
    bit          mb[NREG];
    bit          mwe, mrr, ga, gm;
    int          mrd;
    logic [31:0] mwd;
    int          checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit hz(input int r);
        return r != 0 && mb[r] && !(BYP && mwe && mrd == r);
    endfunction

    task automatic model_reset();
        foreach (mb[i]) mb[i] = 1'b0;
        mwe = 1'b0; mrd = 0; mwd = '0; mrr = 1'b0;
    endtask

    // Compare every output against the model, then advance the model one clock.
    task automatic step();
        bit ea, em, es;
        int cnt;
        #1;
        ea  = a_valid && (!m_valid || !mrr);
        em  = m_valid && (!a_valid || mrr);
        es  = issue_valid && (hz(int'(q_rs1)) || hz(int'(q_rs2)) || hz(int'(issue_rd)));
        cnt = 0;
        foreach (mb[i]) cnt += int'(mb[i]);
        chk("a_ready", 64'(a_ready), 64'(ea));
        chk("m_ready", 64'(m_ready), 64'(em));
        chk("stall", 64'(stall), 64'(es));
        chk("rf_we", 64'(rf_we), 64'(mwe));
        chk("pend_cnt", 64'(pend_cnt), 64'(cnt));
        if (mwe) begin
            chk("rf_rd", 64'(rf_rd), 64'(mrd));
            chk("rf_wd", 64'(rf_wd), 64'(mwd));
        end
`ifdef RF_WB_BYPASS_EN
        chk("byp1_hit", 64'(byp1_hit), 64'(mwe && mrd == int'(q_rs1) && q_rs1 != 0));
        chk("byp2_hit", 64'(byp2_hit), 64'(mwe && mrd == int'(q_rs2) && q_rs2 != 0));
        if (mwe) chk("byp_data", 64'(byp_data), 64'(mwd));
`endif
        ga = ea; gm = em;
        @(posedge clk);
        if (mwe) mb[mrd] = 1'b0;
        if (issue_valid && !es && issue_rd != 0) mb[issue_rd] = 1'b1;
        if (a_valid && m_valid) mrr = !mrr;
        if (ea || em) begin
            mrd = ea ? int'(a_rd) : int'(m_rd);
            mwd = ea ? a_data : m_data;
            mwe = (mrd != 0);
        end else mwe = 1'b0;
        @(negedge clk);
    endtask

    bit ap, mp;

    initial begin
        model_reset();
        a_valid = 1'b1; m_valid = 1'b1;
        #1;
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_rd", 64'(rf_rd), 64'd0);
        chk("rst_wd", 64'(rf_wd), 64'd0);
        chk("rst_pend", 64'(pend_cnt), 64'd0);
        chk("rst_ardy", 64'(a_ready), 64'd0);
        chk("rst_mrdy", 64'(m_ready), 64'd0);
        a_valid = 1'b0; m_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // x0 issue never marks busy
        issue_valid = 1'b1; issue_rd = 5'd7; step();
        issue_rd = 5'd0; #1 chk("x0_stall", 64'(stall), 64'd0); step();
        issue_valid = 1'b0; #1 chk("x0_pend", 64'(pend_cnt), 64'd1);

        // RAW on x7 resolved by an ALU write
        issue_valid = 1'b1; issue_rd = 5'd0; q_rs1 = 5'd7;
        a_valid = 1'b1; a_rd = 5'd7; a_data = 32'hDEADBEEF;
        #1 chk("raw_stall", 64'(stall), 64'd1);
        chk("raw_ardy", 64'(a_ready), 64'd1);
        step();
        a_valid = 1'b0;
        #1 chk("raw_we", 64'(rf_we), 64'd1);
        chk("raw_rd", 64'(rf_rd), 64'd7);
        chk("raw_wd", 64'(rf_wd), 64'hDEADBEEF);
        chk("raw_stall_ret", 64'(stall), BYP ? 64'd0 : 64'd1);
`ifdef RF_WB_BYPASS_EN
        chk("raw_byp1", 64'(byp1_hit), 64'd1);
`endif
        step();
        #1 chk("raw_clear", 64'(stall), 64'd0);
        chk("raw_pend", 64'(pend_cnt), 64'd0);
        issue_valid = 1'b0; q_rs1 = 5'd0; step();

        // Contention: ALU, MEM, ALU, MEM
        a_valid = 1'b1; m_valid = 1'b1; a_rd = 5'd1; m_rd = 5'd2; a_data = 32'h11; m_data = 32'h22;
        #1 chk("ct1_a", 64'(a_ready), 64'd1); step();
        a_rd = 5'd3; a_data = 32'h33;
        #1 chk("ct2_m", 64'(m_ready), 64'd1); chk("ct2_rd", 64'(rf_rd), 64'd1); step();
        m_rd = 5'd4; m_data = 32'h44;
        #1 chk("ct3_a", 64'(a_ready), 64'd1); chk("ct3_rd", 64'(rf_rd), 64'd2); step();
        a_rd = 5'd5; a_data = 32'h55;
        #1 chk("ct4_m", 64'(m_ready), 64'd1); chk("ct4_rd", 64'(rf_rd), 64'd3); step();
        m_valid = 1'b0;
        #1 chk("ct5_rd", 64'(rf_rd), 64'd4); chk("ct5_we", 64'(rf_we), 64'd1); step();
        a_valid = 1'b0;
        #1 chk("ct6_rd", 64'(rf_rd), 64'd5); step();

        // Write to x0 is accepted but not performed
        m_valid = 1'b1; m_rd = 5'd0; m_data = 32'h99;
        #1 chk("x0w_rdy", 64'(m_ready), 64'd1); step();
        m_valid = 1'b0;
        #1 chk("x0w_we", 64'(rf_we), 64'd0); chk("x0w_pend", 64'(pend_cnt), 64'd0); step();

        // WAW stall, then issue x3 while x9 retires
        issue_valid = 1'b1; issue_rd = 5'd9; step();
        #1 chk("waw_stall", 64'(stall), 64'd1); step();
        issue_valid = 1'b0;
        #1 chk("waw_pend", 64'(pend_cnt), 64'd1);
        a_valid = 1'b1; a_rd = 5'd9; a_data = $urandom; step();
        a_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd3;
        #1 chk("swap_stall", 64'(stall), 64'd0); chk("swap_rd", 64'(rf_rd), 64'd9); step();
        issue_rd = 5'd0; q_rs1 = 5'd9;
        #1 chk("swap_pend", 64'(pend_cnt), 64'd1); chk("swap_b9", 64'(stall), 64'd0);
        q_rs1 = 5'd3;
        #1 chk("swap_b3", 64'(stall), 64'd1);
        issue_valid = 1'b0; q_rs1 = 5'd0; step();

        // Asynchronous reset mid-write
        issue_valid = 1'b1; issue_rd = 5'd5; step();
        issue_valid = 1'b0; a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h5A5A; step();
        #1 chk("mid_we", 64'(rf_we), 64'd1);
        #1 reset = 1'b1;
        #1 chk("mid_rst_we", 64'(rf_we), 64'd0);
        chk("mid_rst_pend", 64'(pend_cnt), 64'd0);
        chk("mid_rst_ardy", 64'(a_ready), 64'd0);
        issue_valid = 1'b1; issue_rd = 5'd0; q_rs1 = 5'd5;
        #1 chk("mid_rst_busy", 64'(stall), 64'd0);
        model_reset();
        issue_valid = 1'b0; q_rs1 = 5'd0; a_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Random traffic; requesters hold their request until granted
        ap = 1'b0; mp = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!ap && $urandom_range(0, 2) != 0) begin
                ap = 1'b1; a_rd = 5'($urandom_range(0, 7)); a_data = $urandom;
            end
            if (!mp && $urandom_range(0, 2) != 0) begin
                mp = 1'b1; m_rd = 5'($urandom_range(0, 7)); m_data = $urandom;
            end
            a_valid = ap; m_valid = mp;
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd = 5'($urandom_range(0, 7));
            q_rs1 = 5'($urandom_range(0, 7));
            q_rs2 = 5'($urandom_range(0, 7));
            step();
            if (ga) ap = 1'b0;
            if (gm) mp = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
